// File: rtl/pwm_ctrl_pkg.sv
// Shared types, default widths and the step-size helper for the PWM duty ramp sequencer.
package pwm_ctrl_pkg;

  localparam int unsigned DefaultDutyW   = 8;
  localparam int unsigned DefaultDivW    = 16;
  localparam int unsigned DefaultRstDuty = 0;

  typedef enum logic [1:0] {
    StIdle,
    StRamp,
    StDone
  } ramp_state_e;

  // min(stp, |a - b|); compared in full 32-bit width so the difference never wraps.
  function automatic int unsigned step_delta(input int unsigned a, input int unsigned b,
                                             input int unsigned stp);
    int unsigned diff;
    diff = (a > b) ? (a - b) : (b - a);
    return (stp < diff) ? stp : diff;
  endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Loadable down-counter that pulses tick_o while running with the count at zero.
module ramp_tick_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_val_i,
  input  logic             run_i,
  input  logic [DIV_W-1:0] reload_val_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (run_i) begin
      cnt_d = (cnt_q == '0) ? reload_val_i : cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Glides the PWM duty toward a commanded target in bounded steps at a programmable tick rate.
// Optional macro RAMP_STEP_COUNT_EN adds a saturating steps_taken counter output.
module pwm_duty_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned        DUTY_W   = DefaultDutyW,
  parameter int unsigned        DIV_W    = DefaultDivW,
  parameter logic [DUTY_W-1:0]  RST_DUTY = DUTY_W'(DefaultRstDuty)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              start,
  input  logic              abort,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic [DUTY_W-1:0] step_size,
  input  logic [DIV_W-1:0]  tick_div,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              done
`ifdef RAMP_STEP_COUNT_EN
  ,
  output logic [15:0]       steps_taken
`endif
);

  ramp_state_e       state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d;
  logic [DUTY_W-1:0] stp_q, stp_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DUTY_W-1:0] stp_in, delta, duty_step;
  logic              tick, tick_load, step_applied, clear_steps;

  assign stp_in    = (step_size == '0) ? DUTY_W'(1) : step_size;
  assign delta     = DUTY_W'(step_delta(32'(tgt_q), 32'(duty_q), 32'(stp_q)));
  assign duty_step = (tgt_q > duty_q) ? duty_q + delta : duty_q - delta;

  ramp_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk          (clk),
    .rst          (rst),
    .load_i       (tick_load),
    .load_val_i   (tick_div),
    .run_i        (enable && (state_q == StRamp)),
    .reload_val_i (div_q),
    .tick_o       (tick)
  );

  always_comb begin
    state_d      = state_q;
    duty_d       = duty_q;
    tgt_d        = tgt_q;
    stp_d        = stp_q;
    div_d        = div_q;
    tick_load    = 1'b0;
    step_applied = 1'b0;
    clear_steps  = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            clear_steps = 1'b1;
            if (target_duty == duty_q) begin
              state_d = StDone;
            end else begin
              tgt_d     = target_duty;
              stp_d     = stp_in;
              div_d     = tick_div;
              tick_load = 1'b1;
              state_d   = StRamp;
            end
          end
        end
        StRamp: begin
          // A retarget keeps the running count so tick spacing is not disturbed.
          if (start) begin
            tgt_d = target_duty;
            stp_d = stp_in;
            div_d = tick_div;
            if (target_duty == duty_q) state_d = StDone;
          end else if (tick) begin
            duty_d       = duty_step;
            step_applied = 1'b1;
            if (duty_step == tgt_q) state_d = StDone;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      duty_q  <= RST_DUTY;
      tgt_q   <= '0;
      stp_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      stp_q   <= stp_d;
      div_q   <= div_d;
    end
  end

  assign duty_out = duty_q;
  assign busy     = (state_q == StRamp);
  assign done     = (state_q == StDone);

`ifdef RAMP_STEP_COUNT_EN
  logic [15:0] steps_q, steps_d;

  always_comb begin
    steps_d = steps_q;
    if (clear_steps) begin
      steps_d = '0;
    end else if (step_applied && (steps_q != 16'hFFFF)) begin
      steps_d = steps_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      steps_q <= '0;
    end else begin
      steps_q <= steps_d;
    end
  end

  assign steps_taken = steps_q;
`else
  logic unused_step_flags;
  assign unused_step_flags = step_applied ^ clear_steps;
`endif

endmodule
